// File: rtl/enc_rpt_pkg.sv
// Shared types and constants for the encoder position reporter.
package enc_rpt_pkg;

    localparam int POS_W        = 16;
    localparam int FRAME_LEN    = 3;
    localparam int FRAME_LEN_CK = 4;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HI,
        ST_LO,
        ST_CK,
        ST_GAP
    } state_t;

endpackage

// File: rtl/enc_pos_counter.sv
// Signed rotary-encoder position accumulator; zero_req wins over step pulses, wraps in two's complement.
module enc_pos_counter
    import enc_rpt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cw_pulse,
    input  logic                    ccw_pulse,
    input  logic                    zero_req,
    output logic signed [POS_W-1:0] position
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position <= '0;
        end else if (zero_req) begin
            position <= '0;
        end else if (cw_pulse && !ccw_pulse) begin
            position <= position + POS_W'(1);
        end else if (ccw_pulse && !cw_pulse) begin
            position <= position - POS_W'(1);
        end
    end

endmodule

// File: rtl/enc_uart_reporter.sv
// Sends position frames over a byte-wide valid/ready TX link whenever the encoder position changes.
// Define ENC_RPT_CHECKSUM_EN to append an XOR checksum byte (4-byte frames instead of 3).
module enc_uart_reporter
    import enc_rpt_pkg::*;
#(
    parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
    parameter int unsigned MIN_GAP_CYC = 120000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cw_pulse,
    input  logic                    ccw_pulse,
    input  logic                    zero_req,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic signed [POS_W-1:0] position,
    output logic                    busy
);

    localparam int GAP_W = (MIN_GAP_CYC < 2) ? 1 : $clog2(MIN_GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP_CYC - 1);

    state_t                   state, state_n;
    logic signed [POS_W-1:0]  snap, snap_n;
    logic signed [POS_W-1:0]  last_sent, last_sent_n;
    logic [7:0]               tx_data_n;
    logic                     tx_valid_n;
    logic [GAP_W-1:0]         gap_cnt, gap_cnt_n;
    logic                     xfer;

`ifdef ENC_RPT_CHECKSUM_EN
    function automatic logic [7:0] frame_ck(input logic [7:0] hdr, input logic [7:0] hi,
                                            input logic [7:0] lo);
        return hdr ^ hi ^ lo;
    endfunction
`endif

    enc_pos_counter u_pos (
        .clk       (clk),
        .rst       (rst),
        .cw_pulse  (cw_pulse),
        .ccw_pulse (ccw_pulse),
        .zero_req  (zero_req),
        .position  (position)
    );

    assign xfer = tx_valid & tx_ready;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            snap      <= '0;
            last_sent <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            snap      <= snap_n;
            last_sent <= last_sent_n;
            tx_data   <= tx_data_n;
            tx_valid  <= tx_valid_n;
            gap_cnt   <= gap_cnt_n;
        end
    end

    // Each byte state loads the following byte on the accepting edge, so bytes go back-to-back.
    always_comb begin
        state_n     = state;
        snap_n      = snap;
        last_sent_n = last_sent;
        tx_data_n   = tx_data;
        tx_valid_n  = tx_valid;
        gap_cnt_n   = gap_cnt;
        case (state)
            ST_IDLE: begin
                tx_valid_n = 1'b0;
                if (position != last_sent) begin
                    snap_n      = position;
                    last_sent_n = position;
                    tx_data_n   = HEADER;
                    tx_valid_n  = 1'b1;
                    state_n     = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    tx_data_n = snap[15:8];
                    state_n   = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    tx_data_n = snap[7:0];
                    state_n   = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
`ifdef ENC_RPT_CHECKSUM_EN
                    tx_data_n = frame_ck(HEADER, snap[15:8], snap[7:0]);
                    state_n   = ST_CK;
`else
                    tx_valid_n = 1'b0;
                    gap_cnt_n  = '0;
                    state_n    = ST_GAP;
`endif
                end
            end
`ifdef ENC_RPT_CHECKSUM_EN
            ST_CK: begin
                if (xfer) begin
                    tx_valid_n = 1'b0;
                    gap_cnt_n  = '0;
                    state_n    = ST_GAP;
                end
            end
`endif
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                tx_valid_n = 1'b0;
                state_n    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_enc_uart_reporter.sv
// Directed bench for enc_uart_reporter: expected frame bytes are queued when stimulus is applied
// and compared as the DUT hands each byte over the TX handshake.
module tb_enc_uart_reporter;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cw_pulse = 1'b0;
    logic        ccw_pulse = 1'b0;
    logic        zero_req = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] position;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    enc_uart_reporter #(.HEADER(8'hA5), .MIN_GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cw_pulse  (cw_pulse),
        .ccw_pulse (ccw_pulse),
        .zero_req  (zero_req),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .position  (position),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] v);
        exp_q.push_back(8'hA5);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
`ifdef ENC_RPT_CHECKSUM_EN
        exp_q.push_back(8'hA5 ^ v[15:8] ^ v[7:0]);
`endif
    endtask

    // Every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("byte_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input logic cw, input logic ccw, input logic z);
        cw_pulse  = cw;
        ccw_pulse = ccw;
        zero_req  = z;
        @(posedge clk); #1;
        cw_pulse  = 1'b0;
        ccw_pulse = 1'b0;
        zero_req  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (2) begin @(posedge clk); #1; end
        while ((busy || tx_valid || exp_q.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_q_empty(input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (exp_q.size() != 0 && n < 400);
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (tx_valid !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int n;
        logic stable;
        #2;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_position", {16'd0, position}, 32'h0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: three cw pulses; first frame snaps 1, follow-up carries 3, then a GAP-cycle idle period
        push_frame(16'h0001);
        step(1, 0, 0);
        push_frame(16'h0003);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t1_position", {16'd0, position}, 32'h0003);
        wait_q_empty("t1_drain");
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t1_gap_len", 32'(n), 32'(GAP));
        wait_idle("t1_idle");

        // 2: zero, one ccw to FFFF, then wrap through 8000/7FFF while the link is stalled
        push_frame(16'h0000);
        step(0, 0, 1);
        wait_idle("t2_zero_idle");
        push_frame(16'hFFFF);
        step(0, 1, 0);
        chk("t2_pos_ffff", {16'd0, position}, 32'hFFFF);
        wait_idle("t2_ffff_idle");
        tx_ready = 1'b0;
        push_frame(16'hFFFE);
        step(0, 1, 0);
        for (int i = 0; i < 32766; i++) step(0, 1, 0);
        chk("t2_pos_8000", {16'd0, position}, 32'h8000);
        step(0, 1, 0);
        chk("t2_wrap_7fff", {16'd0, position}, 32'h7FFF);
        step(1, 0, 0);
        chk("t2_wrap_8000", {16'd0, position}, 32'h8000);
        chk("t2_stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("t2_stall_hdr", {24'd0, tx_data}, 32'hA5);
        push_frame(16'h8000);
        tx_ready = 1'b1;
        wait_idle("t2_wrap_idle");

        // 3: simultaneous cw/ccw does nothing; zero_req beats cw
        step(1, 1, 0);
        chk("t3_both_pos", {16'd0, position}, 32'h8000);
        quiet("t3_no_frame", 10);
        push_frame(16'h0000);
        step(1, 0, 1);
        chk("t3_zero_wins", {16'd0, position}, 32'h0000);
        wait_idle("t3_idle");

        // 4: stall 50 cycles in HI while position keeps moving
        tx_ready = 1'b0;
        push_frame(16'h0001);
        step(1, 0, 0);
        @(posedge clk); #1;
        chk("t4_hdr_valid", {31'd0, tx_valid}, 32'd1);
        chk("t4_hdr_data", {24'd0, tx_data}, 32'hA5);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cw_pulse = (i >= 10 && i < 15);
            @(posedge clk); #1;
            cw_pulse = 1'b0;
            if (!(tx_valid === 1'b1 && tx_data === 8'h00)) stable = 1'b0;
        end
        chk("t4_hi_stable", {31'd0, stable}, 32'd1);
        chk("t4_position", {16'd0, position}, 32'h0006);
        push_frame(16'h0006);
        tx_ready = 1'b1;
        wait_idle("t4_idle");

        // 5: ten cw pulses inside GAP coalesce into a single frame
        push_frame(16'h0007);
        step(1, 0, 0);
        wait_q_empty("t5_drain");
        chk("t5_in_gap", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk("t5_position", {16'd0, position}, 32'h0011);
        push_frame(16'h0011);
        wait_idle("t5_idle");
        quiet("t5_single_frame", 40);

        // 6: asynchronous reset while LO is being offered
        push_frame(16'h0012);
        step(1, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        chk("t6_lo_data", {24'd0, tx_data}, 32'h12);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("t6_rst_position", {16'd0, position}, 32'h0000);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
`ifdef ENC_RPT_CHECKSUM_EN
        chk("t6_left_bytes", 32'(exp_q.size()), 32'd2);
`else
        chk("t6_left_bytes", 32'(exp_q.size()), 32'd1);
`endif
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        quiet("t6_no_resume", 30);
        push_frame(16'h0001);
        step(1, 0, 0);
        wait_idle("t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
